// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
//
// Serial data engine of the SPI master core. It sits directly downstream of
// spi_clockgen and consumes that block's single-cycle edge strobes. A
// parallel word is loaded into the data register and then shifted out on
// s_out. s_in is sampled back into the same register, so when the transfer
// ends the register holds the received character.
//
// Bits are indexed in transfer order, so the register is never physically
// shifted. Transmitted and received bits therefore share one storage
// element. On any bit position the transmit read always precedes the
// receive write.
//
// Parameters
//   SPI_MAX_CHAR       maximum character length in bits, also the width of
//                      the data register
//   SPI_CHAR_LEN_BITS  width of len; must equal log2(SPI_MAX_CHAR)
//
// Ports
//   wb_clk_in   in   system clock, every state change on its rising edge
//   wb_rst      in   asynchronous active-low reset
//   len         in   bits per transfer, 0 selects SPI_MAX_CHAR
//   lsb         in   1: LSB first, 0: MSB first
//   tx_negedge  in   1: drive s_out on cpol_1 strobes, 0: on cpol_0 strobes
//   rx_negedge  in   1: sample s_in on cpol_1 strobes, 0: on cpol_0 strobes
//   go          in   one-cycle start request (honoured only when idle)
//   load        in   one-cycle parallel load strobe (honoured only when idle)
//   p_in        in   parallel write data
//   cpol_0      in   rising-edge strobe from spi_clockgen
//   cpol_1      in   falling-edge strobe from spi_clockgen
//   loop        in   (SPI_SHIFT_LOOPBACK_EN only) sample s_out instead of s_in
//   s_in        in   serial data in (MISO)
//   tip         out  transfer in progress
//   last_clk    out  final bit of the transfer is pending
//   s_out       out  serial data out (MOSI)
//   p_out       out  data register contents, visible at all times
//
// Build option
//   SPI_SHIFT_LOOPBACK_EN  adds the 'loop' input. When loop is 1, the
//                          registered s_out is sampled in place of s_in.
// ---------------------------------------------------------------------------
module spi_shift_reg #(
  parameter int SPI_MAX_CHAR      = 32,
  parameter int SPI_CHAR_LEN_BITS = 5
) (
  input  logic                         wb_clk_in,
  input  logic                         wb_rst,
  input  logic [SPI_CHAR_LEN_BITS-1:0] len,
  input  logic                         lsb,
  input  logic                         tx_negedge,
  input  logic                         rx_negedge,
  input  logic                         go,
  input  logic                         load,
  input  logic [SPI_MAX_CHAR-1:0]      p_in,
  input  logic                         cpol_0,
  input  logic                         cpol_1,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                         loop,
`endif
  input  logic                         s_in,
  output logic                         tip,
  output logic                         last_clk,
  output logic                         s_out,
  output logic [SPI_MAX_CHAR-1:0]      p_out
);

  // The counter needs one extra bit so that it can hold SPI_MAX_CHAR itself.
  localparam int CW = SPI_CHAR_LEN_BITS + 1;
  localparam int IW = SPI_CHAR_LEN_BITS;

  localparam logic [CW-1:0] MAX_LEN = CW'(SPI_MAX_CHAR);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    tip_q, tip_d;
  logic                    s_out_q, s_out_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SPI_MAX_CHAR-1:0] data_q, data_d;

  logic          tx_stb;
  logic          rx_stb;
  logic          rx_bit;
  logic [CW-1:0] eff_len;
  logic [IW-1:0] len_lo;
  logic [IW-1:0] cnt_lo;
  logic [IW-1:0] idx_tx;
  logic [IW-1:0] idx_rx;

  // Each direction picks the clock edge it works on independently.
  assign tx_stb = tx_negedge ? cpol_1 : cpol_0;
  assign rx_stb = rx_negedge ? cpol_1 : cpol_0;

  // A programmed length of 0 selects a full-width character.
  assign eff_len = (len == '0) ? MAX_LEN : {1'b0, len};

  // The bit indices are computed in IW-bit arithmetic, which wraps them
  // modulo SPI_MAX_CHAR. That wrap is intended: when both strobes share an
  // edge, the first sample uses the pre-decrement count, so it lands at
  // position "L" (MSB first) or position "-1" (LSB first). Either one
  // wraps back into the register.
  assign len_lo = eff_len[IW-1:0];
  assign cnt_lo = cnt_q[IW-1:0];
  assign idx_tx = lsb ? (len_lo - cnt_lo) : (cnt_lo - IDX_ONE);
  assign idx_rx = lsb ? (len_lo - cnt_lo - IDX_ONE) : cnt_lo;

`ifdef SPI_SHIFT_LOOPBACK_EN
  // In loopback the serial input is the registered MOSI value. The line
  // therefore reads back whatever was last driven onto it.
  assign rx_bit = loop ? s_out_q : s_in;
`else
  assign rx_bit = s_in;
`endif

  // Next-state logic for the transfer engine.
  // While IDLE, only load and go are acted on. While XFER, only the
  // strobes are acted on. The transmit path reads data_q (the old
  // contents) and the receive path writes data_d. Because of this, a
  // shift-out and a sample in the same cycle never interfere.
  always_comb begin
    state_d = state_q;
    tip_d   = tip_q;
    s_out_d = s_out_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = p_in;
        end
        if (go) begin
          state_d = XFER;
          tip_d   = 1'b1;
          cnt_d   = eff_len;
        end
      end

      XFER: begin
        if (tx_stb && (cnt_q != '0)) begin
          s_out_d = data_q[idx_tx];
          cnt_d   = cnt_q - CNT_ONE;
        end
        // A sample taken after the count has reached zero is the last bit
        // of the character, so the transfer closes on it.
        if (rx_stb) begin
          data_d[idx_rx] = rx_bit;
          if (cnt_q == '0) begin
            tip_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All engine state lives in this one register bank. Reset is
  // asynchronous and wipes everything, even in the middle of a transfer.
  always_ff @(posedge wb_clk_in or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= IDLE;
      tip_q   <= 1'b0;
      s_out_q <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tip_q   <= tip_d;
      s_out_q <= s_out_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // last_clk tells spi_clockgen that only the closing sample is left. It
  // is gated by tip, so it drops in the same cycle as tip.
  assign last_clk = tip_q & (cnt_q == '0);
  assign tip      = tip_q;
  assign s_out    = s_out_q;
  assign p_out    = data_q;

endmodule

// File: tb/tb_spi_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_spi_shift_reg
//
// Bench for spi_shift_reg. It plays the role of spi_clockgen by issuing
// cpol_0/cpol_1 strobes. The bench keeps a reference model of each
// character: the bit order of the transfer and the value that each bit
// position ends up holding. For every transfer, the expected MOSI bits and
// the expected final register word are queued. A separate monitor
// retires them as the DUT shifts bits out and drops tip.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_shift_reg;

  logic        wb_clk_in;
  logic        wb_rst;
  logic [4:0]  len;
  logic        lsb;
  logic        tx_negedge;
  logic        rx_negedge;
  logic        go;
  logic        load;
  logic [31:0] p_in;
  logic        cpol_0;
  logic        cpol_1;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic        loop;
`endif
  logic        s_in;
  logic        tip;
  logic        last_clk;
  logic        s_out;
  logic [31:0] p_out;

  int checks = 0;
  int errors = 0;

  bit          expBits[$];
  logic [31:0] expWords[$];
  bit          modelSout;

  spi_shift_reg #(
    .SPI_MAX_CHAR     (32),
    .SPI_CHAR_LEN_BITS(5)
  ) dut (
    .wb_clk_in (wb_clk_in),
    .wb_rst    (wb_rst),
    .len       (len),
    .lsb       (lsb),
    .tx_negedge(tx_negedge),
    .rx_negedge(rx_negedge),
    .go        (go),
    .load      (load),
    .p_in      (p_in),
    .cpol_0    (cpol_0),
    .cpol_1    (cpol_1),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loop      (loop),
`endif
    .s_in      (s_in),
    .tip       (tip),
    .last_clk  (last_clk),
    .s_out     (s_out),
    .p_out     (p_out)
  );

  // Free-running system clock, 10 ns period.
  initial wb_clk_in = 1'b0;
  always #5 wb_clk_in = ~wb_clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT produced output with nothing expected at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge wb_clk_in);
    #1;
  endtask

  task automatic idleInputs();
    go     = 1'b0;
    load   = 1'b0;
    cpol_0 = 1'b0;
    cpol_1 = 1'b0;
  endtask

  // Drives one strobe cycle on the edge selected by 'neg'.
  task automatic pulseLine(input bit neg, input bit sinVal);
    if (neg) cpol_1 = 1'b1;
    else     cpol_0 = 1'b1;
    s_in = sinVal;
    tick();
    cpol_0 = 1'b0;
    cpol_1 = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // One complete character. The reference model walks the bit positions
  // in transfer order. For each strobe event it records the bit that goes
  // out and the register position that the sample lands in.
  task automatic applyStimulus(input logic [31:0] word, input logic [4:0] lenVal,
                               input bit lsbVal, input bit txNeg, input bit rxNeg,
                               input logic [63:0] sinBits, input bit loadWithGo,
                               input bit injectMid, input bit loopVal);
    int          nBits;
    int          nEv;
    int          tgt;
    bit          simul;
    bit          txBit;
    bit          sb;
    int          order[$];
    logic [31:0] m;

    nBits = (lenVal == 5'd0) ? 32 : int'(lenVal);
    simul = (txNeg == rxNeg);
    // When both strobes share an edge, one extra strobe is needed to take
    // the closing sample.
    nEv   = simul ? nBits + 1 : nBits;
    for (int k = 0; k < nBits; k++) order.push_back(lsbVal ? k : nBits - 1 - k);

    m = word;
    for (int j = 0; j < nEv; j++) begin
      txBit = (j < nBits) ? m[order[j]] : modelSout;
      if (simul) begin
        // The sample lags the shift-out by one position. The very first
        // sample lands on the position just before the first bit, wrapped
        // into the register.
        sb  = loopVal ? modelSout : sinBits[j];
        tgt = (j == 0) ? (((lsbVal ? -1 : nBits) + 32) % 32) : order[j-1];
      end else begin
        sb  = loopVal ? txBit : sinBits[j];
        tgt = order[j];
      end
      if (j < nBits) expBits.push_back(txBit);
      m[tgt]    = sb;
      modelSout = txBit;
    end
    expWords.push_back(m);

    len        = lenVal;
    lsb        = lsbVal;
    tx_negedge = txNeg;
    rx_negedge = rxNeg;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loop       = loopVal;
`endif

    // Strobes arriving while idle must be ignored.
    if (!loadWithGo) begin
      p_in   = word;
      load   = 1'b1;
      cpol_0 = 1'($urandom);
      cpol_1 = 1'($urandom);
      tick();
      idleInputs();
    end
    p_in   = loadWithGo ? word : $urandom;
    load   = loadWithGo;
    go     = 1'b1;
    cpol_0 = 1'($urandom);
    cpol_1 = 1'($urandom);
    tick();
    idleInputs();
    checkOutput("tip_after_go", 32'(tip), 32'd1);
    checkOutput("last_clk_after_go", 32'(last_clk), 32'd0);

    for (int j = 0; j < nEv; j++) begin
      gap();
      if (injectMid && (j == nBits / 2)) begin
        p_in = 32'hFFFF_FFFF;
        load = 1'b1;
        go   = 1'b1;
        tick();
        idleInputs();
        checkOutput("tip_after_ignored_go", 32'(tip), 32'd1);
      end
      if (simul) begin
        pulseLine(txNeg, sinBits[j]);
        if (j < nBits) checkOutput("last_clk_after_tx", 32'(last_clk), 32'(j == nBits - 1));
        checkOutput("tip_after_strobe", 32'(tip), 32'(j != nBits));
      end else begin
        pulseLine(txNeg, 1'($urandom));
        checkOutput("last_clk_after_tx", 32'(last_clk), 32'(j == nBits - 1));
        gap();
        pulseLine(rxNeg, sinBits[j]);
        checkOutput("tip_after_rx", 32'(tip), 32'(j != nBits - 1));
      end
    end
    gap();
  endtask

  // Monitor: a shift is visible one cycle after a transmit strobe that
  // arrives while tip is high and last_clk is low. A completed character
  // is visible when tip falls.
  initial begin : monitor
    bit prevTip;
    bit prevShift;
    bit prevValid;
    prevTip   = 1'b0;
    prevShift = 1'b0;
    prevValid = 1'b0;
    forever begin
      @(negedge wb_clk_in);
      if (!wb_rst) begin
        prevValid = 1'b0;
      end else begin
        if (prevValid && prevShift) begin
          if (expBits.size() == 0) reportFail("s_out_unexpected_shift");
          else checkOutput("s_out_bit", 32'(s_out), 32'(expBits.pop_front()));
        end
        if (prevValid && prevTip && !tip) begin
          if (expWords.size() == 0) reportFail("p_out_unexpected_end");
          else checkOutput("p_out_word", p_out, expWords.pop_front());
        end
        prevTip   = tip;
        prevShift = tip && !last_clk && (tx_negedge ? cpol_1 : cpol_0);
        prevValid = 1'b1;
      end
    end
  end

  initial begin
    logic [63:0] rnd;
    bit          txr;
    bit          rxr;
    bit          lp;

    wb_rst     = 1'b0;
    idleInputs();
    len        = 5'd0;
    lsb        = 1'b0;
    tx_negedge = 1'b0;
    rx_negedge = 1'b0;
    p_in       = 32'd0;
    s_in       = 1'b0;
    modelSout  = 1'b0;
`ifdef SPI_SHIFT_LOOPBACK_EN
    loop       = 1'b0;
`endif

    #12;
    checkOutput("reset_tip", 32'(tip), 32'd0);
    checkOutput("reset_last_clk", 32'(last_clk), 32'd0);
    checkOutput("reset_s_out", 32'(s_out), 32'd0);
    checkOutput("reset_p_out", p_out, 32'd0);
    tick();
    wb_rst = 1'b1;
    tick();

    $display("[TB] MSB-first 8-bit, s_in held high");
    applyStimulus(32'h0000_00A5, 5'd8, 1'b0, 1'b1, 1'b0, {64{1'b1}}, 1'b0, 1'b0, 1'b0);

    $display("[TB] LSB-first full-width character");
    applyStimulus(32'h8000_0001, 5'd0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

    $display("[TB] load/go ignored mid-transfer");
    applyStimulus($urandom, 5'd16, 1'b0, 1'b1, 1'b0, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    applyStimulus($urandom, 5'd0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);

    $display("[TB] load and go together");
    applyStimulus(32'h0000_003C, 5'd8, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] shared-edge strobes");
    applyStimulus($urandom, 5'd8, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 5'd0, 1'b0, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 5'd0, 1'b1, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 5'd1, 1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

`ifdef SPI_SHIFT_LOOPBACK_EN
    $display("[TB] loopback");
    applyStimulus(32'h0000_005A, 5'd8, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] reset in the middle of a transfer");
    len        = 5'd8;
    lsb        = 1'b0;
    tx_negedge = 1'b1;
    rx_negedge = 1'b0;
    p_in       = 32'h0000_00E0;
    load       = 1'b1;
    tick();
    idleInputs();
    go = 1'b1;
    tick();
    idleInputs();
    for (int k = 0; k < 3; k++) expBits.push_back(1'b1);
    for (int k = 0; k < 3; k++) begin
      pulseLine(1'b1, 1'b0);
      if (k < 2) pulseLine(1'b0, 1'b1);
    end
    @(negedge wb_clk_in);
    #2;
    wb_rst = 1'b0;
    #1;
    checkOutput("midreset_tip", 32'(tip), 32'd0);
    checkOutput("midreset_last_clk", 32'(last_clk), 32'd0);
    checkOutput("midreset_s_out", 32'(s_out), 32'd0);
    checkOutput("midreset_p_out", p_out, 32'd0);
    expBits.delete();
    expWords.delete();
    modelSout = 1'b0;
    tick();
    tick();
    wb_rst = 1'b1;
    tick();
    applyStimulus(32'h0000_00C3, 5'd8, 1'b0, 1'b1, 1'b0, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 40; t++) begin
      rnd = {$urandom, $urandom};
      txr = 1'($urandom);
      rxr = ($urandom_range(0, 3) == 0) ? txr : !txr;
`ifdef SPI_SHIFT_LOOPBACK_EN
      lp  = ($urandom_range(0, 3) == 0);
`else
      lp  = 1'b0;
`endif
      applyStimulus($urandom, 5'($urandom_range(0, 31)), 1'($urandom), txr, rxr, rnd,
                    1'($urandom), ($urandom_range(0, 3) == 0), lp);
    end

    repeat (3) tick();
    checkOutput("bits_queue_drained", 32'(expBits.size()), 32'd0);
    checkOutput("words_queue_drained", 32'(expWords.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
